perf_counter_display: RTL
=========================

# perf_counter_display

Board-side statistics and display stage that sits directly downstream of the pipelined CPU top. It consumes the CPU's per-cycle status strobes (`halted`, `jumped`, `is_branch`, `branched`, `load_use`, `predict`, `predict_success`) and its `display` word. It accumulates 32-bit event counters, selects one value by switch, and time-multiplexes that value as 8 hex digits onto a common-anode seven-segment array.

## Interface
Parameters:
- `ScanDiv`, 17: the digit index advances every 2^ScanDiv clocks. The legal range is 1–24.

Ports:
- `clk` in 1: system clock, the same clock as the CPU.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `en` in 1: CPU run enable. Counting is gated by it; scanning is not.
- `halted` in 1: CPU halted, from the WB stage.
- `jumped` in 1: EX-stage unconditional jump strobe.
- `is_branch` in 1: EX-stage conditional-branch-present strobe.
- `branched` in 1: EX-stage branch-taken strobe.
- `load_use` in 1: ID-stage load-use stall strobe.
- `predict` in 1: EX-stage prediction-was-taken strobe.
- `predict_success` in 1: EX-stage prediction-correct strobe.
- `display` in 32: syscall display word.
- `sel` in 3: value select.
- `value` out 32: the currently selected value, registered.
- `an` out 8: digit enables, active-low. Bit i selects digit i, and digit 0 is the rightmost.
- `seg` out 8: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Count qualifier: `cnt_en = en & ~halted`. No counter changes when `cnt_en` = 0.
- Counters are 7 × 32 bits, each incremented by 1 on a rising edge when `cnt_en` is high and its condition holds:
  - C1 cycles: unconditional.
  - C2 jumps: `jumped`.
  - C3 branches: `is_branch`.
  - C4 taken: `branched`.
  - C5 load-use: `load_use`.
  - C6 predictions: `predict`.
  - C7 predict-ok: `predict_success`.
- Counters wrap modulo 2^32 (0xFFFFFFFF → 0) with no saturation or flag.
- Multiple strobes active in the same cycle each increment their own counter independently.
- If `halted` rises in the same cycle as any strobe, that strobe is not counted, and the cycles counter C1 does not count that cycle either. After that, all counters stay frozen until reset.
- `sel` mapping: 0 = `display`, 1 = C1, 2 = C2, 3 = C3, 4 = C4, 5 = C5, 6 = C6, 7 = C7.
- Scan counter: (ScanDiv+3) bits, free-running. It increments every clock regardless of `en` and `halted`, and wraps to 0. Its top 3 bits form the digit index `d`.
- Display: `an` = ~(1<<d). `seg` is the hex glyph of `value[4d+3:4d]`, with dp always off (bit7 = 1).
- Glyph table (hex, active-low):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0
  - 4 = 99, 5 = 92, 6 = 82, 7 = F8
  - 8 = 80, 9 = 90, A = 88, b = 83
  - C = C6, d = A1, E = 86, F = 8E
- Counters are cleared only by reset. There is no software clear.

## Timing
- Reset values:
  - all counters = 0
  - scan counter = 0
  - `value` = 0
  - `an` = FF (all digits dark)
  - `seg` = FF
- Reset asserted mid-count or mid-scan clears everything immediately, asynchronously. The first edge after release behaves exactly as after power-on.
- Strobe to counter: a strobe sampled at edge k makes the counter hold its new value after edge k.
- Counter or `sel` to `value`: `value` shows the new counter content or the new `sel` choice after the following edge, i.e. `value` lags the counter by 1 clock.
- `value` to display: `an` and `seg` are registered from the current `d` and `value`, so the display lags `value` by 1 clock.
  - The first edge after reset release drives `an` = FE and `seg` = glyph of `value[3:0]`.
- Each digit stays lit for exactly 2^ScanDiv clocks. A full refresh takes 2^(ScanDiv+3) clocks.
- Changing `sel` mid-scan causes no glitch beyond the 2-cycle pipeline. The digits shown before the change show old nibbles until they are revisited.

## Test plan
- Reset then idle, with `ScanDiv` = 2, `en` = 1, and no strobes for 10 clocks → C1 = 10 and `sel` = 1 gives `value` = 0x0000000A one clock later. `an` steps FE, FD, FB, … every 4 clocks, and digit 0 `seg` = 88.
- Simultaneous strobes: hold `jumped`, `is_branch`, `branched`, `predict`, and `predict_success` high for 5 clocks → C2 = C3 = C4 = C6 = C7 = 5 and C5 = 0.
- Enable and halt gating: count 3 `load_use` clocks, then drop `en` for 4 clocks with `load_use` high → C5 stays 3 and C1 gains only the enabled cycles. Then raise `halted` together with `jumped` → C2 is unchanged and C1 is frozen thereafter.
- Wrap-around: force C1 to 0xFFFFFFFE via backdoor, then run 3 enabled clocks → C1 = 0x00000001.
- Display path: `sel` = 0 with `display` = 0x12345678, then scan a full 32-clock refresh (`ScanDiv` = 2) → `seg` sequence per digit 0..7 is 80, F8, 82, 92, 99, B0, A4, F9.
- Reset mid-operation: assert `rst_n` = 0 asynchronously between edges with counters nonzero → `value`, `an`, `seg`, and all counters read 0/FF/FF/0 before the next edge.

Source files
------------

// File: rtl/perf_counter_display.sv
// CPU event counters (gated by en & ~halted, frozen after halt) selected onto an 8-digit seven-segment scan.
// value lags counters/sel by 1 clock, an/seg lag value by 1 clock; no backpressure, everything free-runs.
module perf_counter_display #(
  parameter int ScanDiv = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        halted,
  input  logic        jumped,
  input  logic        is_branch,
  input  logic        branched,
  input  logic        load_use,
  input  logic        predict,
  input  logic        predict_success,
  input  logic [31:0] display,
  input  logic [2:0]  sel,
  output logic [31:0] value,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int ScanW = ScanDiv + 3;

  logic             frozen_q, frozen_d;
  logic             cnt_en;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      ev_q [6];
  logic [31:0]      ev_d [6];
  logic [5:0]       ev_hit;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [2:0]       digit;
  logic [3:0]       nib;
  logic [31:0]      value_q, value_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  function automatic logic [7:0] glyph(input logic [3:0] h);
    logic [7:0] g;
    g = 8'hFF;
    case (h)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      4'hF: g = 8'h8E;
    endcase
    return g;
  endfunction

  always_comb begin
    // A halt latches: counting never resumes until reset, even if halted drops again.
    cnt_en   = en & ~halted & ~frozen_q;
    frozen_d = frozen_q | halted;
    ev_hit   = {predict_success, predict, load_use, branched, is_branch, jumped};
    cyc_d    = cyc_q + {31'd0, cnt_en};
    for (int i = 0; i < 6; i++) begin
      ev_d[i] = ev_q[i] + {31'd0, cnt_en & ev_hit[i]};
    end
    scan_d = scan_q + ScanW'(1);
    digit  = scan_q[ScanW-1 -: 3];

    value_d = display;
    case (sel)
      3'd0: value_d = display;
      3'd1: value_d = cyc_q;
      3'd2: value_d = ev_q[0];
      3'd3: value_d = ev_q[1];
      3'd4: value_d = ev_q[2];
      3'd5: value_d = ev_q[3];
      3'd6: value_d = ev_q[4];
      3'd7: value_d = ev_q[5];
    endcase

    nib   = value_q[{digit, 2'b00} +: 4];
    an_d  = ~(8'd1 << digit);
    seg_d = glyph(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_q <= 1'b0;
      cyc_q    <= '0;
      for (int i = 0; i < 6; i++) begin
        ev_q[i] <= '0;
      end
      scan_q   <= '0;
      value_q  <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      frozen_q <= frozen_d;
      cyc_q    <= cyc_d;
      for (int i = 0; i < 6; i++) begin
        ev_q[i] <= ev_d[i];
      end
      scan_q   <= scan_d;
      value_q  <= value_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign value = value_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
